// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle RV32I control FSM. Sequences one instruction over 3-5 states,
// sharing a single ALU and one unified memory port with the multi-cycle
// datapath (PC, OldPC, IR, ALUOut, Data registers). Memory accesses use a
// req/ready handshake, so any number of wait states is tolerated.
//
// Parameters
//   EXT_ALU     0: 3-bit alu_control (add/sub/and/or/slt)
//               1: 4-bit alu_control, adds xor/sll/srl/sra/sltu
//   BRANCH_ALL  0: beq only; 1: beq/bne/blt/bge/bltu/bgeu
//   ALUC_W      derived width of alu_control (3 + EXT_ALU)
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   opcode/funct3/funct7b5 instruction fields from IR
//   zero, lt, ltu         ALU flags (lt/ltu only consulted with BRANCH_ALL=1)
//   mem_ready             memory completes the current access this cycle
//   mem_req, mem_write    memory access request / access is a store
//   adr_src               0: PC, 1: ALUOut drives the memory address
//   ir_write, pc_write    IR / PC load enables
//   reg_write             register file write enable
//   result_src            00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a             00 PC, 01 OldPC, 10 rs1
//   alu_src_b             00 rs2, 01 imm, 10 const 4
//   imm_src               00 I, 01 S, 10 B, 11 J (combinational from opcode)
//   alu_control           0 add, 1 sub, 2 and, 3 or, 5 slt;
//                         EXT: 4 xor, 6 sll, 7 srl, 8 sra, 9 sltu
//   instr_done            1-cycle pulse on the last cycle of each instruction
//   illegal               sticky flag, set on entry to TRAP
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter  int EXT_ALU    = 0,
  parameter  int BRANCH_ALL = 0,
  localparam int ALUC_W     = 3 + EXT_ALU
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_write,
  output logic              adr_src,
  output logic              ir_write,
  output logic              pc_write,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        imm_src,
  output logic [ALUC_W-1:0] alu_control,
  output logic              instr_done,
  output logic              illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BRANCH,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  state_t  state_q, state_d;
  logic    illegal_q;
  alu_op_t alu_op;

  // ---------------------------------------------------------------------------
  // Funct decode for R-type and I-type ALU instructions
  // ---------------------------------------------------------------------------
  alu_op_t func_op;
  logic    func_bad;
  logic    is_rtype;

  assign is_rtype = (opcode == OP_RTYPE);

  always_comb begin
    func_op  = ALU_ADD;
    func_bad = 1'b0;
    case (funct3)
      3'b000: func_op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010: func_op = ALU_SLT;
      3'b110: func_op = ALU_OR;
      3'b111: func_op = ALU_AND;
      3'b100: begin
        if (EXT_ALU != 0) func_op = ALU_XOR;
        else              func_bad = 1'b1;
      end
      3'b001: begin
        if (EXT_ALU != 0) func_op = ALU_SLL;
        else              func_bad = 1'b1;
      end
      3'b101: begin
        if (EXT_ALU != 0) func_op = funct7b5 ? ALU_SRA : ALU_SRL;
        else              func_bad = 1'b1;
      end
      3'b011: begin
        if (EXT_ALU != 0) func_op = ALU_SLTU;
        else              func_bad = 1'b1;
      end
      default: func_bad = 1'b1;
    endcase
    // funct7b5 only selects sub/sra on R-type; on I-type it is immediate data
    // except for the shift-immediates, where slli must have it clear.
    if (is_rtype && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101))
      func_bad = 1'b1;
    if (!is_rtype && (funct3 == 3'b001) && funct7b5)
      func_bad = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Branch condition decode
  // ---------------------------------------------------------------------------
  logic br_taken;
  logic br_bad;

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_bad   = 1'b1;
    endcase
    if ((BRANCH_ALL == 0) && (funct3 != 3'b000))
      br_bad = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Immediate format select (purely from opcode)
  // ---------------------------------------------------------------------------
  always_comb begin
    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and sticky illegal flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  assign illegal     = illegal_q;
  assign alu_control = ALUC_W'(alu_op);

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target is computed here and parked in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = func_bad ? S_TRAP : S_EXECR;
          OP_ITYPE:          state_d = func_bad ? S_TRAP : S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = br_bad ? S_TRAP : S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)
          state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = func_op;
        state_d   = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = func_op;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms OldPC+4
        // for the link write in ALUWB.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end

      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = ALU_SUB;
        result_src = 2'b00;
        pc_write   = br_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule
